// File: rtl/sample_loader_pkg.sv
// Shared widths, boolean constants and FSM encoding for the bank I sample loader.
package sample_loader_pkg;

    localparam int SRAM_ADDR_LEN = 15;
    localparam int REG_WORD_LEN  = 16;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

endpackage

// File: rtl/sample_loader_if.sv
// Input sample stream plus bank I sram write port, bundled as one bus.
interface sample_loader_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              write_en;

    modport master (
        output s_valid, s_data,
        input  s_ready, write_addr, write_data, write_en
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, write_addr, write_data, write_en
    );
endinterface

// File: rtl/sample_loader.sv
// Streams valid/ready samples into consecutive bank I words; one-shot or ring-buffer
// capture with frame completion pulse.
module sample_loader
    import sample_loader_pkg::*;
#(
    parameter int                ADDR_W    = SRAM_ADDR_LEN,
    parameter int                DATA_W    = REG_WORD_LEN,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              circular,
    input  logic [ADDR_W-1:0] frame_len,
    sample_loader_if.slave    bus,
    output logic              busy,
    output logic              frame_done,
    output logic              len_err,
    output logic [ADDR_W-1:0] word_cnt
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] len_q;
    logic              circ_q;
    logic              hs;
    logic              last;

    assign bus.s_ready = (state == ST_CAPTURE) && !abort;
    assign hs          = bus.s_valid && bus.s_ready;
    // word_cnt doubles as the frame index: both clear together and step together.
    assign last        = (word_cnt == len_q - ADDR_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            len_q          <= '0;
            circ_q         <= FALSE;
            word_cnt       <= '0;
            busy           <= FALSE;
            frame_done     <= FALSE;
            len_err        <= FALSE;
            bus.write_en   <= FALSE;
            bus.write_addr <= '0;
            bus.write_data <= '0;
        end else begin
            bus.write_en <= hs;
            frame_done   <= hs && last;
            len_err      <= FALSE;
            if (hs) begin
                bus.write_addr <= BASE_ADDR + word_cnt;
                bus.write_data <= bus.s_data;
            end

            if (abort) begin
                state <= ST_IDLE;
                busy  <= FALSE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (frame_len == '0) begin
                                len_err <= TRUE;
                            end else begin
                                state    <= ST_CAPTURE;
                                busy     <= TRUE;
                                len_q    <= frame_len;
                                circ_q   <= circular;
                                word_cnt <= '0;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        if (hs) begin
                            if (last && circ_q) word_cnt <= '0;
                            else                word_cnt <= word_cnt + ADDR_W'(1);
                            if (last && !circ_q) begin
                                state <= ST_DONE;
                                busy  <= FALSE;
                            end
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
